// File: rtl/ceespu_bht_predictor_if.sv
//------------------------------------------------------------------------------
// Module      : ceespu_bht_predictor_if
// Description : Fetch/execute side signal bundle of the branch history table.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ceespu_bht_predictor_if #(
    parameter int PC_W = 14
);
    logic [PC_W-1:0] I_PC;
    logic [31:0]     I_instruction;
    logic            prediction;
    logic [1:0]      prediction_state;
    logic [PC_W-1:0] branch_address;
    logic [1:0]      branch_prediction_state;
    logic            branch_taken;
    logic            update_table;

    modport master (
        output I_PC, I_instruction, branch_address, branch_prediction_state,
               branch_taken, update_table,
        input  prediction, prediction_state
    );

    modport slave (
        input  I_PC, I_instruction, branch_address, branch_prediction_state,
               branch_taken, update_table,
        output prediction, prediction_state
    );
endinterface

`default_nettype wire

// File: rtl/ceespu_bht_predictor.sv
//------------------------------------------------------------------------------
// Module      : ceespu_bht_predictor
// Description : Direct-mapped table of 2-bit saturating counters predicting
//               branch direction at fetch, trained from execute.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ceespu_bht_predictor #(
    parameter int         IDX_W       = 6,
    parameter int         PC_W        = 14,
    parameter logic [5:0] OPC_BRANCH  = 6'b111110,
    parameter logic [2:0] COND_ALWAYS = 3'b111,
    parameter logic [1:0] RESET_STATE = 2'b01
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    ceespu_bht_predictor_if.slave      bus
);
    localparam int c_ENTRIES = 2 ** IDX_W;

    logic [1:0]       r_table [c_ENTRIES];

    logic [PC_W-1:0]  w_readPc;
    logic [PC_W-1:0]  w_writePc;
    logic [IDX_W-1:0] w_readIdx;
    logic [IDX_W-1:0] w_writeIdx;
    logic [1:0]       w_readState;
    logic [1:0]       w_nextState;
    logic             w_isBranch;
    logic [2:0]       w_cond;
    logic             w_prediction;

    assign w_readPc    = bus.I_PC;
    assign w_writePc   = bus.branch_address;
    assign w_readIdx   = w_readPc[IDX_W-1:0];
    assign w_writeIdx  = w_writePc[IDX_W-1:0];
    assign w_readState = r_table[w_readIdx];

    assign w_isBranch  = (bus.I_instruction[31:26] == OPC_BRANCH);
    assign w_cond      = bus.I_instruction[23:21];

    always_comb begin
        w_prediction = 1'b0;
        if (!rst && w_isBranch) begin
            if (w_cond == COND_ALWAYS)
                w_prediction = 1'b1;
            else
                w_prediction = w_readState[1];
        end
    end

    assign bus.prediction       = w_prediction;
    assign bus.prediction_state = w_readState;

    // Training uses the snapshot carried from fetch, not the live entry,
    // so an intervening update to the same slot is deliberately overwritten.
    always_comb begin
        w_nextState = bus.branch_prediction_state;
        if (bus.branch_taken) begin
            if (bus.branch_prediction_state != 2'b11)
                w_nextState = bus.branch_prediction_state + 2'b01;
        end else begin
            if (bus.branch_prediction_state != 2'b00)
                w_nextState = bus.branch_prediction_state - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_ENTRIES; i++)
                r_table[i] <= RESET_STATE;
        end else if (bus.update_table) begin
            r_table[w_writeIdx] <= w_nextState;
        end
    end

    logic w_unused;
    assign w_unused = ^{w_readPc[PC_W-1:IDX_W], w_writePc[PC_W-1:IDX_W],
                        bus.I_instruction[25:24], bus.I_instruction[20:0]};

endmodule

`default_nettype wire

// File: tb/tb_ceespu_bht_predictor.sv
//------------------------------------------------------------------------------
// Module      : tb_ceespu_bht_predictor
// Description : Directed plus random bench for the branch history table.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ceespu_bht_predictor;
    localparam int IDX_W = 6;
    localparam int PC_W  = 14;
    localparam int NENT  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ceespu_bht_predictor_if #(.PC_W(PC_W)) bif ();

    ceespu_bht_predictor #(.IDX_W(IDX_W), .PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int model [NENT];
    int total = 0;
    int bad   = 0;

    function automatic int satNext(input int s, input bit t);
        if (t) return (s >= 3) ? 3 : s + 1;
        return (s <= 0) ? 0 : s - 1;
    endfunction

    function automatic logic [31:0] mkInstr(input bit br, input logic [2:0] cond);
        logic [31:0] w;
        w = $urandom;
        w[23:21] = cond;
        if (br) w[31:26] = 6'b111110;
        else if (w[31:26] == 6'b111110) w[31:26] = 6'b000000;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs and compare outputs with the reference model
    task automatic drive(input string tag, input bit r, input logic [13:0] pc,
                         input logic [31:0] ins, input bit upd, input logic [13:0] ba,
                         input logic [1:0] bs, input bit bt);
        int idx, expP;
        rst                         = r;
        bif.I_PC                    = pc;
        bif.I_instruction           = ins;
        bif.update_table            = upd;
        bif.branch_address          = ba;
        bif.branch_prediction_state = bs;
        bif.branch_taken            = bt;
        #1;
        idx = int'(pc) % NENT;
        if (r) expP = 0;
        else if (ins[31:26] != 6'b111110) expP = 0;
        else if (ins[23:21] == 3'b111) expP = 1;
        else expP = (model[idx] >= 2) ? 1 : 0;
        chk({tag, "_pred"}, {31'd0, bif.prediction}, expP);
        chk({tag, "_state"}, {30'd0, bif.prediction_state}, model[idx]);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NENT; i++) model[i] = 1;
        end else if (bif.update_table) begin
            model[int'(bif.branch_address) % NENT] =
                satNext(int'(bif.branch_prediction_state), bif.branch_taken);
        end
        @(negedge clk);
    endtask

    initial begin
        bif.I_PC = '0; bif.I_instruction = '0; bif.update_table = 1'b0;
        bif.branch_address = '0; bif.branch_prediction_state = '0; bif.branch_taken = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Reset state
        drive("rst_cond", 0, 14'd5, mkInstr(1, 3'b000), 0, 0, 0, 0);
        chk("rst_state_const", {30'd0, bif.prediction_state}, 1);
        chk("rst_pred_const", {31'd0, bif.prediction}, 0);
        tick();
        drive("rst_nonbr", 0, 14'd5, mkInstr(0, 3'b000), 0, 0, 0, 0);
        tick();

        // Unconditional branch, and forced low under reset
        drive("uncond", 0, 14'd9, mkInstr(1, 3'b111), 0, 0, 0, 0);
        chk("uncond_const", {31'd0, bif.prediction}, 1);
        tick();
        drive("uncond_rst", 1, 14'd9, mkInstr(1, 3'b111), 0, 0, 0, 0);
        chk("uncond_rst_const", {31'd0, bif.prediction}, 0);
        tick();

        // Train toward taken
        drive("tr_t1", 0, 14'd5, mkInstr(1, 3'b010), 1, 14'd5, 2'd1, 1);
        tick();
        drive("tr_t2", 0, 14'd5, mkInstr(1, 3'b010), 1, 14'd5, 2'd2, 1);
        chk("tr_t2_const", {30'd0, bif.prediction_state}, 2);
        chk("tr_t2_pred_const", {31'd0, bif.prediction}, 1);
        tick();
        drive("tr_sat3", 0, 14'd5, mkInstr(1, 3'b010), 1, 14'd5, 2'd3, 1);
        tick();
        drive("tr_sat3b", 0, 14'd5, mkInstr(1, 3'b010), 0, 0, 0, 0);
        chk("sat3_const", {30'd0, bif.prediction_state}, 3);
        tick();

        // Snapshot semantics with read/write collision
        drive("coll", 0, 14'd5, mkInstr(1, 3'b001), 1, 14'd5, 2'd0, 1);
        chk("coll_old_const", {30'd0, bif.prediction_state}, 3);
        tick();
        drive("snap", 0, 14'd5, mkInstr(1, 3'b001), 0, 0, 0, 0);
        chk("snap_const", {30'd0, bif.prediction_state}, 1);
        tick();

        // Train toward not taken, including floor saturation
        drive("tr_n1", 0, 14'd5, mkInstr(1, 3'b100), 1, 14'd5, 2'd2, 0);
        tick();
        drive("tr_n2", 0, 14'd5, mkInstr(1, 3'b100), 1, 14'd5, 2'd0, 0);
        chk("tr_n2_pred_const", {31'd0, bif.prediction}, 0);
        tick();
        drive("sat0", 0, 14'd5, mkInstr(1, 3'b100), 0, 0, 0, 0);
        chk("sat0_const", {30'd0, bif.prediction_state}, 0);
        tick();

        // Aliasing, then reset overriding a simultaneous update
        drive("alias_w", 0, 14'd5, mkInstr(1, 3'b011), 1, 14'd69, 2'd1, 1);
        tick();
        drive("alias_r", 0, 14'd5, mkInstr(1, 3'b011), 0, 0, 0, 0);
        chk("alias_const", {30'd0, bif.prediction_state}, 2);
        tick();
        drive("rst_upd", 1, 14'd5, mkInstr(1, 3'b011), 1, 14'd5, 2'd3, 1);
        tick();
        drive("rst_upd_r", 0, 14'd5, mkInstr(1, 3'b011), 0, 0, 0, 0);
        chk("rst_upd_const", {30'd0, bif.prediction_state}, 1);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [13:0] pc, ba;
            logic [2:0]  cond;
            logic [1:0]  bs;
            bit          r, br, upd, bt;
            r    = ($urandom % 40) == 0;
            pc   = 14'($urandom);
            br   = ($urandom % 4) != 0;
            cond = (($urandom % 4) == 0) ? 3'b111 : 3'($urandom);
            upd  = $urandom % 2;
            ba   = ($urandom % 3 == 0) ? pc : 14'($urandom);
            bs   = ($urandom % 2) ? 2'(model[int'(ba) % NENT]) : 2'($urandom);
            bt   = $urandom % 2;
            drive("rnd", r, pc, mkInstr(br, cond), upd, ba, bs, bt);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ceespu_bht_predictor.md
Name: ceespu_bht_predictor

Overview:
Dynamic branch predictor for the ceespu fetch stage, built on a direct-mapped table of 2-bit saturating counters indexed by PC.
- Fetch side: combinationally inspects the just-fetched instruction and its PC, and raises a taken prediction that redirects the PC to the instruction's embedded target.
- Execute side: when a resolved conditional branch arrives, updates the counter that was read at fetch time, using the counter snapshot carried down the pipeline.

Parameters:
IDX_W, 6, number of PC bits used as table index (table has 2^IDX_W entries)
PC_W, 14, width of word-granular PC
OPC_BRANCH, 6'b111110, value of I_instruction[31:26] identifying a branch instruction
COND_ALWAYS, 3'b111, branch condition code meaning unconditional
RESET_STATE, 2'b01, counter value loaded into every entry on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
I_PC  input  PC_W  word PC of the instruction on I_instruction
I_instruction  input  32  fetched instruction word
prediction  output  1  1 = redirect fetch to predicted target this cycle
prediction_state  output  2  counter value read at I_PC, piped downstream by the core
branch_address  input  PC_W  PC of the branch being resolved in execute
branch_prediction_state  input  2  counter snapshot taken when that branch was fetched
branch_taken  input  1  resolved outcome of that branch
update_table  input  1  1 = write the updated counter for branch_address this edge

Behaviour:
Decode of the fetched instruction:
- is_branch = (I_instruction[31:26] == OPC_BRANCH).
- cond = I_instruction[23:21].
- unconditional = is_branch && cond == COND_ALWAYS.
- conditional = is_branch && cond != COND_ALWAYS.

Table read (fully combinational, no latency):
- idx_r = I_PC[IDX_W-1:0].
- prediction_state = table[idx_r] at all times, for both branch and non-branch instructions.

Prediction (combinational):
- prediction = 1 if unconditional.
- prediction = 1 if conditional and table[idx_r][1] == 1 (state 2 or 3).
- prediction = 0 otherwise.
- prediction is forced to 0 while rst = 1.

Counter encoding:
- 0 = strongly not taken, 1 = weakly not taken, 2 = weakly taken, 3 = strongly taken.

Table update (rising edge, update_table = 1, rst = 0):
- idx_w = branch_address[IDX_W-1:0].
- New value is computed from branch_prediction_state, not from the current table contents:
  - taken: min(state + 1, 3).
  - not taken: max(state − 1, 0).
- Saturation is required at both ends; 3 + taken stays 3, 0 + not taken stays 0.
- The caller (core) never asserts update_table for unconditional branches; the block does not filter this itself.

Reset:
- Synchronous. On any rising edge with rst = 1, every entry is loaded with RESET_STATE and any update that cycle is discarded.
- Reset may be asserted mid-stream; the next cycle the table is uniformly RESET_STATE.

Read/write collision:
- When idx_r == idx_w in the same cycle, prediction and prediction_state reflect the old (pre-edge) value. The new value is visible from the next cycle.

Aliasing:
- PCs that differ only above bit IDX_W−1 share an entry. This is accepted; no tags.

Test Plan:
1. Reset → idle: rst high one edge, then I_PC=5 with a conditional branch (cond=000) → prediction_state=01, prediction=0; same PC with non-branch opcode → prediction=0, prediction_state=01.
2. Unconditional branch: I_instruction[31:26]=111110, cond=111 at any PC, state 01 → prediction=1; during rst=1 → prediction=0.
3. Training to taken: update_table=1, branch_address=5, branch_prediction_state=01, branch_taken=1 → next cycle entry 5 = 10, conditional branch at I_PC=5 → prediction=1. Repeat from state 11 with taken → stays 11.
4. Training to not taken: state 10, taken=0 → 01, prediction=0; state 00, taken=0 → stays 00.
5. Snapshot semantics and collision:
   - Table entry 5 = 11, update with branch_prediction_state=00, taken=1 → entry becomes 01, not 11.
   - During the update cycle with I_PC=5 → prediction_state=11 (old value).
6. Aliasing and priority:
   - Update at branch_address=5+64 → I_PC=5 reflects the change.
   - rst=1 together with update_table=1 → entry holds RESET_STATE afterwards.
